// File: rtl/rr_bus_arbiter.sv
// Round-robin N-master to M-slave single-outstanding bus arbiter with address-field slave decode.
// Latency: grant is combinational in IDLE; response reaches the master 2 cycles after grant at best.
// Backpressure: command held until s_ready_i; response waits for s_rvalid_i (watchdog with ARB_TIMEOUT_EN).
module rr_bus_arbiter #(
    parameter int MASTERS        = 2,
    parameter int SLAVES         = 4,
    parameter int SEL_LSB        = 28,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [MASTERS-1:0]            m_req_i,
    input  logic [MASTERS-1:0][31:0]      m_addr_i,
    input  logic [MASTERS-1:0]            m_we_i,
    input  logic [MASTERS-1:0][3:0]       m_be_i,
    input  logic [MASTERS-1:0][31:0]      m_wdata_i,
    output logic [MASTERS-1:0]            m_gnt_o,
    output logic [MASTERS-1:0]            m_rvalid_o,
    output logic [MASTERS-1:0]            m_err_o,
    output logic [31:0]                   m_rdata_o,
    output logic [SLAVES-1:0]             s_req_o,
    output logic [31:0]                   s_addr_o,
    output logic                          s_we_o,
    output logic [3:0]                    s_be_o,
    output logic [31:0]                   s_wdata_o,
    input  logic [SLAVES-1:0]             s_ready_i,
    input  logic [SLAVES-1:0]             s_rvalid_i,
    input  logic [SLAVES-1:0][31:0]       s_rdata_i
);

    localparam int MW = (MASTERS > 1) ? $clog2(MASTERS) : 1;
    localparam int SW = (SLAVES > 1) ? $clog2(SLAVES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [MW-1:0]  last_winner;
    logic [MW-1:0]  win_idx;
    logic           win_found;
    logic           grant;
    logic           cmd_drive;
    logic [SW-1:0]  dec_sel;
    logic           dec_err;
    logic [31:0]    lat_addr;
    logic [31:0]    lat_wdata;
    logic           lat_we;
    logic [3:0]     lat_be;
    logic [SW-1:0]  lat_sel;
    logic           lat_err;
    logic           sel_ready;
    logic           sel_rvalid;
    logic [31:0]    sel_rdata;
    logic           timeout;

    // Search starts one past the previous winner so every requester gets a turn.
    always_comb begin
        int cand;
        cand      = 0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int i = 1; i <= MASTERS; i++) begin
            cand = (int'(last_winner) + i) % MASTERS;
            if (!win_found && m_req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = MW'(cand);
            end
        end
    end

    generate
        if (SLAVES > 1) begin : g_dec
            assign dec_sel = m_addr_i[win_idx][SEL_LSB +: SW];
        end else begin : g_dec_single
            assign dec_sel = '0;
        end
    endgenerate

    assign dec_err = (32'(dec_sel) >= 32'(SLAVES));

    always_comb begin
        sel_ready  = 1'b0;
        sel_rvalid = 1'b0;
        sel_rdata  = '0;
        for (int s = 0; s < SLAVES; s++) begin
            if (32'(lat_sel) == 32'(s)) begin
                sel_ready  = s_ready_i[s];
                sel_rvalid = s_rvalid_i[s];
                sel_rdata  = s_rdata_i[s];
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_cnt <= '0;
        end else if (grant) begin
            tmo_cnt <= '0;
        end else if (state != IDLE && !timeout) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    assign timeout = (state != IDLE) && (32'(tmo_cnt) >= 32'(TIMEOUT_CYCLES));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        grant      = 1'b0;
        cmd_drive  = 1'b0;
        m_gnt_o    = '0;
        m_rvalid_o = '0;
        m_err_o    = '0;
        m_rdata_o  = '0;
        s_req_o    = '0;
        case (state)
            IDLE: begin
                if (win_found) begin
                    grant            = 1'b1;
                    m_gnt_o[win_idx] = !rst_i;
                    state_nxt        = CMD;
                end
            end
            CMD: begin
                if (timeout) begin
                    m_rvalid_o[last_winner] = 1'b1;
                    m_err_o[last_winner]    = 1'b1;
                    state_nxt               = IDLE;
                end else if (lat_err) begin
                    state_nxt = RESP;
                end else begin
                    cmd_drive = 1'b1;
                    for (int s = 0; s < SLAVES; s++) begin
                        s_req_o[s] = (32'(lat_sel) == 32'(s));
                    end
                    if (sel_ready) begin
                        state_nxt = RESP;
                    end
                end
            end
            RESP: begin
                if (timeout || lat_err) begin
                    m_rvalid_o[last_winner] = 1'b1;
                    m_err_o[last_winner]    = 1'b1;
                    state_nxt               = IDLE;
                end else if (sel_rvalid) begin
                    m_rvalid_o[last_winner] = 1'b1;
                    m_rdata_o               = sel_rdata;
                    state_nxt               = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign s_addr_o  = cmd_drive ? lat_addr  : '0;
    assign s_we_o    = cmd_drive ? lat_we    : 1'b0;
    assign s_be_o    = cmd_drive ? lat_be    : '0;
    assign s_wdata_o = cmd_drive ? lat_wdata : '0;

    // last_winner doubles as the owner of the in-flight transaction.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_winner <= MW'(MASTERS - 1);
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_we      <= 1'b0;
            lat_be      <= '0;
            lat_sel     <= '0;
            lat_err     <= 1'b0;
        end else if (grant) begin
            last_winner <= win_idx;
            lat_addr    <= m_addr_i[win_idx];
            lat_wdata   <= m_wdata_i[win_idx];
            lat_we      <= m_we_i[win_idx];
            lat_be      <= m_be_i[win_idx];
            lat_sel     <= dec_sel;
            lat_err     <= dec_err;
        end
    end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Bench for rr_bus_arbiter: directed scenarios then randomized transactions against a round-robin model.
module tb_rr_bus_arbiter;

    localparam int M   = 2;
    localparam int S   = 3;
    localparam int TMO = 16;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [M-1:0]         m_req, m_we, m_gnt, m_rvalid, m_err;
    logic [M-1:0][31:0]   m_addr, m_wdata;
    logic [M-1:0][3:0]    m_be;
    logic [31:0]          m_rdata;
    logic [S-1:0]         s_req, s_ready, s_rvalid;
    logic [31:0]          s_addr, s_wdata;
    logic                 s_we;
    logic [3:0]           s_be;
    logic [S-1:0][31:0]   s_rdata;

    int n_vec = 0;
    int n_bad = 0;
    int last_w;

    always #5 clk = ~clk;

    rr_bus_arbiter #(
        .MASTERS(M), .SLAVES(S), .SEL_LSB(28), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .m_req_i(m_req), .m_addr_i(m_addr), .m_we_i(m_we), .m_be_i(m_be), .m_wdata_i(m_wdata),
        .m_gnt_o(m_gnt), .m_rvalid_o(m_rvalid), .m_err_o(m_err), .m_rdata_o(m_rdata),
        .s_req_o(s_req), .s_addr_o(s_addr), .s_we_o(s_we), .s_be_o(s_be), .s_wdata_o(s_wdata),
        .s_ready_i(s_ready), .s_rvalid_i(s_rvalid), .s_rdata_i(s_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] oh(input int i);
        return 32'd1 << i;
    endfunction

    // First requester found scanning upward from the master after the previous winner.
    function automatic int rr_pick(input int last, input logic [M-1:0] req);
        for (int i = 1; i <= M; i++) begin
            if (req[(last + i) % M]) return (last + i) % M;
        end
        return -1;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_slave_data();
        for (int i = 0; i < S; i++) s_rdata[i] = $urandom;
    endtask

    // Called one time unit after a rising edge with the arbiter idle and requests driven.
    task automatic txn(input int rdy_dly, input int rv_dly, input logic [31:0] rd, input bit keep);
        int          w, sel, lat;
        logic [31:0] a, e_wdata;
        logic        e_we;
        logic [3:0]  e_be;
        #1;
        w = rr_pick(last_w, m_req);
        chk("grant", 32'(m_gnt), (w < 0) ? 32'd0 : oh(w));
        if (w < 0) return;
        last_w  = w;
        a       = m_addr[w];
        e_we    = m_we[w];
        e_be    = m_be[w];
        e_wdata = m_wdata[w];
        sel     = int'(a[29:28]);
        cyc();
        lat = 1;
        if (!keep) begin
            m_req[w]   = 1'b0;
            m_addr[w]  = $urandom;
            m_wdata[w] = $urandom;
            m_we[w]    = ~m_we[w];
            m_be[w]    = ~m_be[w];
        end
        if (sel >= S) begin
            s_rvalid = 3'b111;
            #1;
            chk("err_cmd_sreq", 32'(s_req), 32'd0);
            chk("err_cmd_rvalid", 32'(m_rvalid), 32'd0);
            cyc();
            lat++;
            s_rvalid = S'($urandom);
            rand_slave_data();
            #1;
            chk("err_rvalid", 32'(m_rvalid), oh(w));
            chk("err_err", 32'(m_err), oh(w));
            chk("err_rdata", m_rdata, 32'd0);
            chk("err_latency", 32'(lat), 32'd2);
            cyc();
        end else begin
            for (int k = 0; k <= rdy_dly; k++) begin
                s_ready  = (k == rdy_dly) ? S'(oh(sel)) : (S'($urandom) & ~S'(oh(sel)));
                s_rvalid = S'($urandom);
                #1;
                chk("cmd_sreq", 32'(s_req), oh(sel));
                chk("cmd_addr", s_addr, a);
                chk("cmd_we", 32'(s_we), 32'(e_we));
                chk("cmd_be", 32'(s_be), 32'(e_be));
                chk("cmd_wdata", s_wdata, e_wdata);
                chk("cmd_rvalid", 32'(m_rvalid), 32'd0);
                chk("cmd_gnt", 32'(m_gnt), 32'd0);
                cyc();
                lat++;
            end
            s_ready = '0;
            for (int k = 0; k <= rv_dly; k++) begin
                rand_slave_data();
                s_rvalid = S'($urandom) & ~S'(oh(sel));
                if (k == rv_dly) begin
                    s_rvalid[sel] = 1'b1;
                    s_rdata[sel]  = rd;
                end
                #1;
                chk("resp_sreq", 32'(s_req), 32'd0);
                chk("resp_gnt", 32'(m_gnt), 32'd0);
                if (k == rv_dly) begin
                    chk("resp_rvalid", 32'(m_rvalid), oh(w));
                    chk("resp_err", 32'(m_err), 32'd0);
                    chk("resp_rdata", m_rdata, rd);
                    chk("resp_latency", 32'(lat), 32'(rdy_dly + rv_dly + 2));
                end else begin
                    chk("resp_wait_rvalid", 32'(m_rvalid), 32'd0);
                end
                cyc();
                lat++;
            end
        end
        s_rvalid = '0;
        s_ready  = '0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rst = 1'b1;
        m_req = 2'b11; m_we = '0; m_be = '0; m_addr = '0; m_wdata = '0;
        s_ready = '0; s_rvalid = '1; s_rdata = '0;
        #2;
        chk("rst_gnt", 32'(m_gnt), 32'd0);
        chk("rst_sreq", 32'(s_req), 32'd0);
        chk("rst_rvalid", 32'(m_rvalid), 32'd0);
        chk("rst_err", 32'(m_err), 32'd0);
        chk("rst_rdata", m_rdata, 32'd0);
        chk("rst_saddr", s_addr, 32'd0);
        cyc(); cyc();
        rst = 1'b0; s_rvalid = '0; m_req = '0;
        last_w = M - 1;

        // Two persistent requesters alternate, starting with master 0.
        m_req = 2'b11;
        m_addr[0] = 32'h0000_0100;
        m_addr[1] = 32'h1000_0200;
        for (int i = 0; i < 4; i++) begin
            chk("alt_expected_winner", 32'(rr_pick(last_w, m_req)), 32'(i % 2));
            txn(0, 0, $urandom, 1'b1);
        end

        m_req = 2'b10; m_addr[1] = 32'h2000_0004; m_we[1] = 1'b0;
        txn(0, 3, 32'hDEAD_BEEF, 1'b0);

        m_req = 2'b01; m_addr[0] = 32'h0000_0010; m_we[0] = 1'b1;
        m_be[0] = 4'b0011; m_wdata[0] = 32'h1234_5678;
        txn(5, 0, 32'h0, 1'b0);

        m_req = 2'b01; m_addr[0] = 32'h3000_0000;
        txn(0, 0, 32'h0, 1'b0);

        m_req = 2'b10; m_addr[1] = 32'h1000_0040;
        txn(0, 1, 32'hA5A5_0001, 1'b1);
        txn(1, 0, 32'hA5A5_0002, 1'b0);

        // Asynchronous reset while a response is being presented.
        m_req = 2'b01; m_addr[0] = 32'h1000_0000;
        #1;
        chk("rstmid_gnt", 32'(m_gnt), 32'd1);
        cyc();
        m_req = 2'b11; s_ready = 3'b010;
        cyc();
        s_ready = '0; s_rvalid = 3'b010; s_rdata[1] = 32'hCAFE_F00D;
        #1;
        chk("rstmid_pre_rvalid", 32'(m_rvalid), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("rstmid_rvalid", 32'(m_rvalid), 32'd0);
        chk("rstmid_rdata", m_rdata, 32'd0);
        chk("rstmid_gnt0", 32'(m_gnt), 32'd0);
        chk("rstmid_sreq", 32'(s_req), 32'd0);
        cyc();
        chk("rstmid_hold_rvalid", 32'(m_rvalid), 32'd0);
        rst = 1'b0; s_rvalid = '0;
        last_w = M - 1;
        m_addr[0] = 32'h0000_0000; m_addr[1] = 32'h0000_0000;
        txn(0, 0, 32'h0BAD_CAFE, 1'b0);

        // Slave that never accepts its command.
        m_req = 2'b01; m_addr[0] = 32'h1000_0000;
        #1;
        chk("stall_gnt", 32'(m_gnt), oh(rr_pick(last_w, m_req)));
        last_w = 0;
        cyc();
        m_req = '0;
`ifdef ARB_TIMEOUT_EN
        for (int k = 0; k < TMO; k++) begin
            #1;
            chk("tmo_sreq", 32'(s_req), 32'd2);
            chk("tmo_rvalid", 32'(m_rvalid), 32'd0);
            cyc();
        end
        #1;
        chk("tmo_sreq_drop", 32'(s_req), 32'd0);
        chk("tmo_rvalid_pulse", 32'(m_rvalid), 32'd1);
        chk("tmo_err_pulse", 32'(m_err), 32'd1);
        chk("tmo_rdata", m_rdata, 32'd0);
        cyc();
        chk("tmo_idle_rvalid", 32'(m_rvalid), 32'd0);
`else
        for (int k = 0; k < 1000; k++) begin
            #1;
            chk("wait_sreq", 32'(s_req), 32'd2);
            chk("wait_rvalid", 32'(m_rvalid), 32'd0);
            cyc();
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        last_w = M - 1;
`endif

        for (int n = 0; n < 60; n++) begin
            m_req = M'($urandom_range(1, 3));
            for (int i = 0; i < M; i++) begin
                m_addr[i]  = $urandom;
                m_wdata[i] = $urandom;
                m_we[i]    = 1'($urandom);
                m_be[i]    = 4'($urandom);
            end
            txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
